// File: rtl/control_unit.sv
// Main decoder for a MIPS subset datapath: opcode/funct in, registered control vector out.
// Optional jump (j, opcode 000010) decode is enabled by defining CTRL_J_INSN_EN.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] special,
    input  logic [5:0] offest,
    output logic [2:0] ALUop,
    output logic [2:0] EXTop,
    output logic [2:0] NPCop,
    output logic       GRFWE,
    output logic       DMWN,
    output logic [2:0] RAsel,
    output logic [2:0] RWsel,
    output logic [2:0] ABsel
);

`ifdef CTRL_J_INSN_EN
    localparam logic J_EN = 1'b1;
`else
    localparam logic J_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef struct packed {
        logic [2:0] aluop;
        logic [2:0] extop;
        logic [2:0] npcop;
        logic       grfwe;
        logic       dmwn;
        logic [2:0] rasel;
        logic [2:0] rwsel;
        logic [2:0] absel;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};

    ctrl_t dec_s;

    // Combinational decode of opcode/funct into the control vector; unknowns map to NOP.
    always_comb begin
        dec_s = CTRL_NOP;
        case (special)
            OP_RTYPE: begin
                case (offest)
                    FN_ADD:  dec_s = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000};
                    FN_SUB:  dec_s = '{3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000};
                    FN_JR:   dec_s = '{3'b000, 3'b000, 3'b011, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
                    default: dec_s = CTRL_NOP;
                endcase
            end
            OP_ORI:  dec_s = '{3'b010, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 3'b000, 3'b001};
            OP_LW:   dec_s = '{3'b000, 3'b001, 3'b000, 1'b1, 1'b0, 3'b000, 3'b001, 3'b001};
            OP_SW:   dec_s = '{3'b000, 3'b001, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 3'b001};
            OP_BEQ:  dec_s = '{3'b001, 3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
            OP_LUI:  dec_s = '{3'b011, 3'b010, 3'b000, 1'b1, 1'b0, 3'b000, 3'b000, 3'b001};
            OP_JAL:  dec_s = '{3'b000, 3'b000, 3'b010, 1'b1, 1'b0, 3'b010, 3'b010, 3'b000};
            OP_J: begin
                if (J_EN) begin
                    dec_s = '{3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
                end else begin
                    dec_s = CTRL_NOP;
                end
            end
            default: dec_s = CTRL_NOP;
        endcase
    end

    // Output register stage; reset forces the NOP vector (PC+4, no writes).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUop <= 3'b000;
            EXTop <= 3'b000;
            NPCop <= 3'b000;
            GRFWE <= 1'b0;
            DMWN  <= 1'b0;
            RAsel <= 3'b000;
            RWsel <= 3'b000;
            ABsel <= 3'b000;
        end else begin
            ALUop <= dec_s.aluop;
            EXTop <= dec_s.extop;
            NPCop <= dec_s.npcop;
            GRFWE <= dec_s.grfwe;
            DMWN  <= dec_s.dmwn;
            RAsel <= dec_s.rasel;
            RWsel <= dec_s.rwsel;
            ABsel <= dec_s.absel;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed steps plus random opcodes against a table model.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] special;
    logic [5:0] offest;
    logic [2:0] ALUop, EXTop, NPCop, RAsel, RWsel, ABsel;
    logic       GRFWE, DMWN;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .special(special), .offest(offest),
        .ALUop(ALUop), .EXTop(EXTop), .NPCop(NPCop), .GRFWE(GRFWE), .DMWN(DMWN),
        .RAsel(RAsel), .RWsel(RWsel), .ABsel(ABsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction table straight from the decode list: opcode, funct, funct-matters, vector.
`ifdef CTRL_J_INSN_EN
    localparam int NTBL = 10;
`else
    localparam int NTBL = 9;
`endif
    logic [5:0]  t_op  [NTBL];
    logic [5:0]  t_fn  [NTBL];
    logic        t_rt  [NTBL];
    logic [19:0] t_vec [NTBL];

    function automatic logic [19:0] vec(input logic [2:0] a, input logic [2:0] e, input logic [2:0] n,
                                        input logic g, input logic d, input logic [2:0] ra,
                                        input logic [2:0] rw, input logic [2:0] ab);
        return {a, e, n, g, d, ra, rw, ab};
    endfunction

    function automatic logic [19:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
        for (int i = 0; i < NTBL; i++) begin
            if (op == t_op[i] && (!t_rt[i] || fn == t_fn[i])) return t_vec[i];
        end
        return 20'h00000;
    endfunction

    function automatic logic [19:0] got();
        return {ALUop, EXTop, NPCop, GRFWE, DMWN, RAsel, RWsel, ABsel};
    endfunction

    task automatic check(input string tag, input logic [19:0] exp);
        logic [19:0] g;
        g = got();
        checks++;
        assert (g === exp) else begin
            errors++;
            $error("FAIL %s observed %05h expected %05h", tag, g, exp);
        end
        checks++;
        assert (!(GRFWE === 1'b1 && DMWN === 1'b1)) else begin
            errors++;
            $error("FAIL %s_we_excl observed GRFWE=%b DMWN=%b expected not both 1", tag, GRFWE, DMWN);
        end
    endtask

    // Present inputs on the falling edge, then check just after the next rising edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        special = op;
        offest  = fn;
        @(posedge clk);
        #1;
        check(tag, ref_decode(op, fn));
    endtask

    logic [5:0] known_ops [8];
    logic [5:0] rop, rfn;
    logic [19:0] prev;

    initial begin
        t_op[0] = 6'b000000; t_fn[0] = 6'b100000; t_rt[0] = 1'b1; t_vec[0] = vec(3'd0,3'd0,3'd0,1'b1,1'b0,3'd1,3'd0,3'd0);
        t_op[1] = 6'b000000; t_fn[1] = 6'b100010; t_rt[1] = 1'b1; t_vec[1] = vec(3'd1,3'd0,3'd0,1'b1,1'b0,3'd1,3'd0,3'd0);
        t_op[2] = 6'b000000; t_fn[2] = 6'b001000; t_rt[2] = 1'b1; t_vec[2] = vec(3'd0,3'd0,3'd3,1'b0,1'b0,3'd0,3'd0,3'd0);
        t_op[3] = 6'b001101; t_fn[3] = 6'b000000; t_rt[3] = 1'b0; t_vec[3] = vec(3'd2,3'd0,3'd0,1'b1,1'b0,3'd0,3'd0,3'd1);
        t_op[4] = 6'b100011; t_fn[4] = 6'b000000; t_rt[4] = 1'b0; t_vec[4] = vec(3'd0,3'd1,3'd0,1'b1,1'b0,3'd0,3'd1,3'd1);
        t_op[5] = 6'b101011; t_fn[5] = 6'b000000; t_rt[5] = 1'b0; t_vec[5] = vec(3'd0,3'd1,3'd0,1'b0,1'b1,3'd0,3'd0,3'd1);
        t_op[6] = 6'b000100; t_fn[6] = 6'b000000; t_rt[6] = 1'b0; t_vec[6] = vec(3'd1,3'd1,3'd1,1'b0,1'b0,3'd0,3'd0,3'd0);
        t_op[7] = 6'b001111; t_fn[7] = 6'b000000; t_rt[7] = 1'b0; t_vec[7] = vec(3'd3,3'd2,3'd0,1'b1,1'b0,3'd0,3'd0,3'd1);
        t_op[8] = 6'b000011; t_fn[8] = 6'b000000; t_rt[8] = 1'b0; t_vec[8] = vec(3'd0,3'd0,3'd2,1'b1,1'b0,3'd2,3'd2,3'd0);
`ifdef CTRL_J_INSN_EN
        t_op[9] = 6'b000010; t_fn[9] = 6'b000000; t_rt[9] = 1'b0; t_vec[9] = vec(3'd0,3'd0,3'd2,1'b0,1'b0,3'd0,3'd0,3'd0);
`endif
        known_ops = '{6'b000000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b001111, 6'b000011, 6'b000010};

        // Reset held with lw on the inputs while the clock runs.
        rst_n = 1'b0; special = 6'b100011; offest = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 20'h00000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_before_edge", 20'h00000);
        @(posedge clk);
        #1;
        check("release_lw", vec(3'd0,3'd1,3'd0,1'b1,1'b0,3'd0,3'd1,3'd1));

        // add then sub, with a lag check between edges.
        step("add", 6'b000000, 6'b100000);
        @(negedge clk);
        offest = 6'b100010;
        #1;
        check("lag_still_add", vec(3'd0,3'd0,3'd0,1'b1,1'b0,3'd1,3'd0,3'd0));
        @(posedge clk);
        #1;
        check("sub", vec(3'd1,3'd0,3'd0,1'b1,1'b0,3'd1,3'd0,3'd0));

        step("ori", 6'b001101, 6'b010101);
        step("lw",  6'b100011, 6'b100010);
        step("sw",  6'b101011, 6'b001000);
        checks++;
        assert (DMWN === 1'b1 && GRFWE === 1'b0) else begin
            errors++; $error("FAIL sw_we observed DMWN=%b GRFWE=%b expected 1/0", DMWN, GRFWE);
        end
        step("beq", 6'b000100, 6'b000000);
        checks++;
        assert (NPCop === 3'b001) else begin
            errors++; $error("FAIL beq_npc observed %b expected 001", NPCop);
        end
        step("lui", 6'b001111, 6'b111111);
        step("jal", 6'b000011, 6'b100000);
        step("jr",  6'b000000, 6'b001000);
        step("sll_nop", 6'b000000, 6'b000000);
        step("op_3f", 6'b111111, 6'b100000);
        step("j", 6'b000010, 6'b000000);

        // Mid-operation reset while jal is registered.
        step("jal2", 6'b000011, 6'b000000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", 20'h00000);
        @(posedge clk);
        #1;
        check("async_reset_stay", 20'h00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_jal", ref_decode(6'b000011, 6'b000000));

        // Random opcodes/functs, biased towards valid encodings.
        for (int i = 0; i < 300; i++) begin
            rop = ($urandom_range(0, 3) == 0) ? 6'($urandom) : known_ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: rfn = 6'b100000;
                1: rfn = 6'b100010;
                2: rfn = 6'b001000;
                default: rfn = 6'($urandom);
            endcase
            prev = got();
            step("random", rop, rfn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for a single-cycle-style MIPS subset datapath.
- Takes the instruction opcode (`special`) and function field (`offest`) and produces ALU, extender, next-PC, register-file, data-memory and mux-select controls.
- Decoded controls are registered: one pipeline stage between the instruction fetch/IR and the datapath.

Parameters:
- None. All widths are fixed: opcode and funct 6 bits, selects 3 bits.

Ports:
- clk      input   1  rising-edge clock
- rst_n    input   1  asynchronous active-low reset
- special  input   6  instruction opcode, bits [31:26]
- offest   input   6  funct field, bits [5:0]; used only when special==000000
- ALUop    output  3  000 add, 001 sub, 010 or, 011 pass B; others reserved
- EXTop    output  3  000 zero-ext, 001 sign-ext, 010 imm<<16 (low half zero)
- NPCop    output  3  000 PC+4, 001 beq target, 010 jump imm26, 011 jump register
- GRFWE    output  1  register-file write enable
- DMWN     output  1  data-memory write enable
- RAsel    output  3  GRF write address: 000 rt, 001 rd, 010 $31
- RWsel    output  3  GRF write data: 000 ALU result, 001 DM read data, 010 PC+4
- ABsel    output  3  ALU B operand: 000 rt data, 001 extended immediate

Behaviour:
- Decode is purely combinational from `special`/`offest`. All eight outputs are registered on the rising edge of `clk`. Latency is exactly 1 cycle; new inputs are visible after the next edge.
- When `rst_n` is low, all outputs go to 0 immediately, independent of `clk`. This is the NOP state: PC+4, no GRF write, no DM write.
- Reset release is handled like any other cycle: the first edge with `rst_n` high loads the decode of the current inputs. Reset asserted mid-operation overrides everything and forces 0.
- Decode table, field order ALUop/EXTop/NPCop/GRFWE/DMWN/RAsel/RWsel/ABsel:
  - add (000000, funct 100000): 000/000/000/1/0/001/000/000
  - sub (000000, funct 100010): 001/000/000/1/0/001/000/000
  - jr (000000, funct 001000): 000/000/011/0/0/000/000/000
  - ori (001101): 010/000/000/1/0/000/000/001
  - lw (100011): 000/001/000/1/0/000/001/001
  - sw (101011): 000/001/000/0/1/000/000/001
  - beq (000100): 001/001/001/0/0/000/000/000
  - lui (001111): 011/010/000/1/0/000/000/001
  - jal (000011): 000/000/010/1/0/010/010/000
- Any other opcode, or opcode 000000 with an unlisted funct (including all-zero sll/nop), decodes to all-zero outputs.
- `offest` is ignored when `special` is not 000000.
- No X propagation: the default branch of every case yields 0.
- GRFWE and DMWN are never both 1.

Optional Feature:
- Macro CTRL_J_INSN_EN.
- Defined: opcode 000010 (j) decodes to 000/000/010/0/0/000/000/000.
- Undefined: opcode 000010 decodes as an unknown instruction (all zeros).

Test Plan:
- rst_n=0 with special=100011 applied, clk toggling → all outputs 0. Release rst_n; after the first edge → lw vector 000/001/000/1/0/000/001/001.
- special=000000, offest=100000 then 100010 on consecutive edges → ALUop 000 then 001; RAsel=001, GRFWE=1 both cycles. Outputs lag the inputs by one edge.
- Sweep ori, lw, sw, beq, lui, jal, one per edge → each registered vector matches the table. Specifically check sw DMWN=1/GRFWE=0, beq NPCop=001, lui EXTop=010/ALUop=011, jal RAsel=010/RWsel=010/NPCop=010.
- special=000000, offest=001000 → NPCop=011, GRFWE=0. Then offest=000000 → all zeros. Then special=111111 → all zeros.
- Assert rst_n low between edges while jal is registered → outputs drop to 0 before the next edge and stay 0 until release.
- special=000010: with CTRL_J_INSN_EN → NPCop=010, GRFWE=0; without it → all zeros.
